cascade_counter: RTL and testbench

Parametrised multi-stage modulo counter: `STAGES` independent modulo-(max+1) digits chained by ripple carry, counting up or down, with synchronous clear/load, wrap or saturate mode, and a sticky overflow flag. Successor to the single-stage max counter; used for time-of-day/frame/line timebases and multi-digit event counters where each digit has its own runtime modulus.

---
 rtl/cascade_counter.sv | 80 ++++++++
 tb/tb_cascade_counter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cascade_counter.sv
// Multi-stage modulo counter: STAGES runtime-modulus digits chained by a
// combinational ripple carry, up/down, wrap or saturate, sticky overflow.
module cascade_counter #(
  parameter int STAGES = 3,
  parameter int DW     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   load,
  input  logic [STAGES*DW-1:0]   load_val,
  input  logic                   en,
  input  logic                   up,
  input  logic                   sat,
  input  logic [STAGES*DW-1:0]   max,
  output logic [STAGES*DW-1:0]   cnt,
  output logic                   co,
  output logic                   ovf
);

  logic [STAGES*DW-1:0] cnt_q;
  logic [STAGES*DW-1:0] cnt_d;
  logic [STAGES:0]      cin;
  logic [STAGES-1:0]    bnd;
  logic                 ovf_q;

  assign cin[0] = en;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic [DW-1:0] cur;
    logic [DW-1:0] lim;
    logic [DW-1:0] step_val;

    assign cur = cnt_q[i*DW +: DW];
    assign lim = max[i*DW +: DW];

    // Out-of-range values (cur > lim) are a boundary going up, so +1 can never
    // pass lim; going down they snap to lim without lending a borrow.
    assign bnd[i]     = up ? (cur >= lim) : (cur == '0);
    assign cin[i+1]   = cin[i] & bnd[i];

    always_comb begin
      step_val = cur;
      if (up) begin
        step_val = (cur >= lim) ? '0 : cur + 1'b1;
      end else begin
        step_val = ((cur == '0) || (cur > lim)) ? lim : cur - 1'b1;
      end
    end

    assign cnt_d[i*DW +: DW] = cin[i] ? step_val : cur;
  end

  assign co = cin[STAGES] & ~clr & ~load;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so every stage samples the
    // pre-edge count; blocking here would let the carry chain race itself.
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (load) begin
      cnt_q <= load_val;
      ovf_q <= 1'b0;
    end else if (co) begin
      // Chain-level boundary: wrap falls out of the per-stage rules; saturate holds.
      if (!sat) cnt_q <= cnt_d;
      ovf_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_cascade_counter.sv
// Self-checking bench for cascade_counter (STAGES=3, DW=8): timebase wrap,
// down wrap, saturate, out-of-range, priority, max=0 and async reset.
module tb_cascade_counter;

  localparam int STAGES = 3;
  localparam int DW     = 8;
  localparam int W      = STAGES * DW;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr, load, en, up, sat;
  logic [W-1:0] load_val, max, cnt;
  logic         co, ovf;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic         clr;
    logic         load;
    logic [W-1:0] lv;
    logic         en;
    logic         up;
    logic         sat;
    logic [W-1:0] mx;
    logic         exp_co;
    logic [W-1:0] exp_cnt;
    logic         exp_ovf;
  } vec_t;

  typedef struct {
    int           id;
    logic [W-1:0] cnt;
    logic         ovf;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  cascade_counter #(.STAGES(STAGES), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .up       (up),
    .sat      (sat),
    .max      (max),
    .cnt      (cnt),
    .co       (co),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] hms(input int h, input int m, input int s);
    return {8'(h), 8'(m), 8'(s)};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: registered results are compared just after each edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check($sformatf("cnt[%0d]", e.id), cnt, e.cnt);
      check($sformatf("ovf[%0d]", e.id), W'(ovf), W'(e.ovf));
    end
  end

  // Called just after a falling edge; returns after the next falling edge.
  task automatic step(input vec_t v, input int id);
    exp_t e;
    clr = v.clr; load = v.load; load_val = v.lv;
    en = v.en; up = v.up; sat = v.sat; max = v.mx;
    #1;
    check($sformatf("co[%0d]", id), W'(co), W'(v.exp_co));
    e.id = id; e.cnt = v.exp_cnt; e.ovf = v.exp_ovf;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic add(input logic c, input logic l, input logic [W-1:0] lv,
                     input logic e, input logic u, input logic s, input logic [W-1:0] mx,
                     input logic xco, input logic [W-1:0] xcnt, input logic xovf);
    vec_t v;
    v.clr = c; v.load = l; v.lv = lv; v.en = e; v.up = u; v.sat = s; v.mx = mx;
    v.exp_co = xco; v.exp_cnt = xcnt; v.exp_ovf = xovf;
    vecs.push_back(v);
  endtask

  initial begin
    logic [W-1:0] tb_max;
    logic [W-1:0] z0max;
    vec_t         hv;
    int           guard;

    tb_max = hms(23, 59, 59);
    z0max  = hms(23, 0, 59);

    // Down wrap, saturate, out-of-range, priority and max=0 sequences.
    add(0,1,hms(0,0,0),   1,0,0,tb_max, 0,hms(0,0,0),    0);
    add(0,0,'0,           1,0,0,tb_max, 1,hms(23,59,59), 1);
    add(0,0,'0,           1,0,0,tb_max, 0,hms(23,59,58), 1);
    add(0,1,hms(23,59,58),0,1,1,tb_max, 0,hms(23,59,58), 0);
    add(0,0,'0,           1,1,1,tb_max, 0,hms(23,59,59), 0);
    add(0,0,'0,           1,1,1,tb_max, 1,hms(23,59,59), 1);
    add(0,0,'0,           1,1,1,tb_max, 1,hms(23,59,59), 1);
    add(0,0,'0,           1,0,1,tb_max, 0,hms(23,59,58), 1);
    add(0,1,hms(0,0,70),  0,1,0,tb_max, 0,hms(0,0,70),   0);
    add(0,0,'0,           1,1,0,tb_max, 0,hms(0,1,0),    0);
    add(0,1,hms(0,0,70),  0,0,0,tb_max, 0,hms(0,0,70),   0);
    add(0,0,'0,           1,0,0,tb_max, 0,hms(0,0,59),   0);
    add(0,1,hms(23,59,59),0,1,0,tb_max, 0,hms(23,59,59), 0);
    add(0,0,'0,           1,1,0,tb_max, 1,hms(0,0,0),    1);
    add(0,0,'0,           1,0,0,tb_max, 1,hms(23,59,59), 1);
    add(1,1,hms(1,2,3),   1,1,0,tb_max, 0,hms(0,0,0),    0);
    add(0,0,'0,           0,1,0,tb_max, 0,hms(0,0,0),    0);
    add(0,1,hms(0,0,59),  0,1,0,z0max,  0,hms(0,0,59),   0);
    add(0,0,'0,           1,1,0,z0max,  0,hms(1,0,0),    0);
    add(0,1,hms(1,0,59),  0,1,0,z0max,  0,hms(1,0,59),   0);
    add(0,0,'0,           1,1,0,z0max,  0,hms(2,0,0),    0);
    add(0,0,'0,           1,0,0,z0max,  0,hms(1,0,59),   0);
    add(0,0,'0,           0,1,0,z0max,  0,hms(1,0,59),   0);

    rst_n = 1'b0; clr = 0; load = 0; load_val = '0; en = 0; up = 1; sat = 0; max = tb_max;
    repeat (2) @(negedge clk);
    #1;
    check("reset_cnt", cnt, '0);
    check("reset_ovf", W'(ovf), '0);
    check("reset_co",  W'(co),  '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Timebase: 86399 enabled edges reach {23,59,59}.
    en = 1'b1;
    repeat (86399) @(negedge clk);
    #1;
    check("tb_cnt_end", cnt, hms(23, 59, 59));
    check("tb_co_end",  W'(co), W'(1'b1));
    check("tb_ovf_pre", W'(ovf), '0);
    hv.clr = 0; hv.load = 0; hv.lv = '0; hv.en = 1; hv.up = 1; hv.sat = 0; hv.mx = tb_max;
    hv.exp_co = 1; hv.exp_cnt = hms(0, 0, 0); hv.exp_ovf = 1;
    step(hv, 1000);

    foreach (vecs[i]) step(vecs[i], i);

    // Reset mid-count: wrap to set ovf, then shrink max so {5,10,20} is reached quickly.
    hv.clr = 0; hv.load = 1; hv.lv = hms(23, 59, 59); hv.en = 0; hv.up = 1; hv.sat = 0;
    hv.mx = tb_max; hv.exp_co = 0; hv.exp_cnt = hms(23, 59, 59); hv.exp_ovf = 0;
    step(hv, 2000);
    hv.load = 0; hv.en = 1; hv.exp_co = 1; hv.exp_cnt = '0; hv.exp_ovf = 1;
    step(hv, 2001);
    max = hms(5, 10, 20);
    guard = 0;
    while (cnt !== hms(5, 10, 20) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    en = 1'b0;
    max = tb_max;
    #1;
    check("pre_rst_cnt", cnt, hms(5, 10, 20));
    check("pre_rst_ovf", W'(ovf), W'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_cnt", cnt, '0);
    check("async_rst_ovf", W'(ovf), '0);
    @(negedge clk);
    rst_n = 1'b1;
    hv.clr = 0; hv.load = 0; hv.lv = '0; hv.en = 1; hv.up = 1; hv.sat = 0; hv.mx = tb_max;
    hv.exp_co = 0; hv.exp_cnt = hms(0, 0, 1); hv.exp_ovf = 0;
    step(hv, 3000);
    hv.exp_cnt = hms(0, 0, 2);
    step(hv, 3001);

    check("sb_drained", W'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
